// File: rtl/playback_ctrl.sv
// -----------------------------------------------------------------------------
// playback_ctrl
// Song playback sequencer. A three-state machine (IDLE / PLAY / PAUSE) walks a
// song ROM one step per quarter beat, and a manual keyboard note overrides the
// ROM note whenever a key is held.
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   RESET         asynchronous, active-high reset
//   play_btn      single-cycle play/pause toggle pulse
//   stop_btn      single-cycle stop pulse (wins over play_btn)
//   song_sel      song to start, sampled only on IDLE -> PLAY
//   tempo         beat period = BASE_DIV >> tempo, sampled at each beat reload
//   loop_en       restart the song at its last step instead of stopping
//   key_note      manual note code, 0 = no key
//   rom_note      ROM note at {song_id, step_addr}
//   rom_last      ROM flag: current step is the last of the song
//   song_id       latched song index to the ROM
//   step_addr     current song step to the ROM
//   note_out      registered arbitrated note to the tone generator
//   beat_tick     one-cycle quarter-beat pulse
//   playing       high while in PLAY
//   manual_active registered (key_note != 0)
// -----------------------------------------------------------------------------
module playback_ctrl #(
  parameter int BASE_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       play_btn,
  input  logic       stop_btn,
  input  logic [1:0] song_sel,
  input  logic [1:0] tempo,
  input  logic       loop_en,
  input  logic [3:0] key_note,
  input  logic [3:0] rom_note,
  input  logic       rom_last,
  output logic [1:0] song_id,
  output logic [5:0] step_addr,
  output logic [3:0] note_out,
  output logic       beat_tick,
  output logic       playing,
  output logic       manual_active
);

  localparam int CNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_new_period;
  logic [1:0]       r_song;
  logic [5:0]       r_step;
  logic [3:0]       r_note;
  logic             r_tick;
  logic             r_playing;
  logic             r_manual;

  logic             w_start;
  logic             w_clear;
  logic             w_count;
  logic             w_beat_end;
  logic             w_tick;

  // The period is only captured at a reload, so a tempo change lands on the
  // next beat boundary and never stretches or cuts the beat in progress.
  assign w_new_period = CNT_W'(BASE_DIV >> tempo);
  assign w_beat_end   = (r_cnt == (r_period - CNT_W'(1)));

  // State register
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode. A button edge consumes the cycle: the beat
  // counter does not advance on the cycle that pauses, resumes or stops.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_clear = 1'b0;
    w_count = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (play_btn && !stop_btn) begin
          w_next  = S_PLAY;
          w_start = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop_btn) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (play_btn) begin
          w_next = S_PAUSE;
        end else begin
          w_count = 1'b1;
          if (w_beat_end && rom_last && !loop_en) begin
            w_next = S_IDLE;
          end
        end
      end
      S_PAUSE: begin
        if (stop_btn) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (play_btn) begin
          w_next = S_PLAY;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_tick = w_count && w_beat_end;

  // Beat counter, step pointer and registered outputs
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_song    <= 2'd0;
      r_step    <= 6'd0;
      r_cnt     <= '0;
      r_period  <= '0;
      r_note    <= 4'd0;
      r_tick    <= 1'b0;
      r_playing <= 1'b0;
      r_manual  <= 1'b0;
    end else begin
      r_tick    <= w_tick;
      r_playing <= (w_next == S_PLAY);
      r_manual  <= (key_note != 4'd0);

      // Manual key has priority; the song keeps running underneath it.
      if (key_note != 4'd0) begin
        r_note <= key_note;
      end else if (r_state != S_IDLE) begin
        r_note <= rom_note;
      end else begin
        r_note <= 4'd0;
      end

      if (w_start) begin
        r_song   <= song_sel;
        r_step   <= 6'd0;
        r_cnt    <= '0;
        r_period <= w_new_period;
      end else if (w_clear) begin
        r_step <= 6'd0;
        r_cnt  <= '0;
      end else if (w_tick) begin
        r_cnt    <= '0;
        r_period <= w_new_period;
        // Last step rewinds whether the song loops or ends; 63 wraps to 0.
        r_step   <= rom_last ? 6'd0 : (r_step + 6'd1);
      end else if (w_count) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign song_id       = r_song;
  assign step_addr     = r_step;
  assign note_out      = r_note;
  assign beat_tick     = r_tick;
  assign playing       = r_playing;
  assign manual_active = r_manual;

endmodule

// File: doc/playback_ctrl.md
PLAYBACK_CTRL -- requirements
Module: playback_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_DIV, default 25_000_000, meaning clock cycles per quarter beat at tempo 0.
REQ-002 The block SHALL have port clk, input, 1 bit, system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset RESET, asynchronous, active-high.
REQ-004 The block SHALL have port play_btn, input, 1 bit, single-cycle play/pause toggle pulse.
REQ-005 The block SHALL have port stop_btn, input, 1 bit, single-cycle stop pulse.
REQ-006 The block SHALL have port song_sel, input, 2 bits, song to start.
REQ-007 The block SHALL have port tempo, input, 2 bits, beat period = BASE_DIV >> tempo cycles.
REQ-008 The block SHALL have port loop_en, input, 1 bit, restart the song at its end instead of stopping.
REQ-009 The block SHALL have port key_note, input, 4 bits, manual keyboard note code; 0 = none.
REQ-010 The block SHALL have port rom_note, input, 4 bits, song ROM note at {song_id, step_addr}, combinational from ROM.
REQ-011 The block SHALL have port rom_last, input, 1 bit, ROM flag: the current step is the last step of the song.
REQ-012 The block SHALL have port song_id, output, 2 bits, latched song index driving the ROM.
REQ-013 The block SHALL have port step_addr, output, 6 bits, current song step driving the ROM.
REQ-014 The block SHALL have port note_out, output, 4 bits, arbitrated note to the tone generator.
REQ-015 The block SHALL have port beat_tick, output, 1 bit, one-cycle quarter-beat pulse.
REQ-016 The block SHALL have port playing, output, 1 bit, high in PLAY state.
REQ-017 The block SHALL have port manual_active, output, 1 bit, registered (key_note != 0).

Function
REQ-018 The FSM SHALL have states IDLE, PLAY and PAUSE.
REQ-019 In IDLE, on play_btn the FSM SHALL go to PLAY, latch song_sel into song_id, set step_addr = 0 and set the beat counter to 0.
REQ-020 In PLAY, on play_btn the FSM SHALL go to PAUSE; in PAUSE, on play_btn it SHALL return to PLAY.
REQ-021 In PLAY or PAUSE, stop_btn SHALL go to IDLE with step_addr = 0 and counter = 0; stop_btn in IDLE SHALL have no effect.
REQ-022 When play_btn and stop_btn are high in the same cycle, stop SHALL win.
REQ-023 Beat counter:
- counts only in PLAY;
- held unchanged in PAUSE;
- 0 in IDLE.
REQ-024 When the counter equals period-1, beat_tick SHALL be 1 for the next cycle and the counter SHALL return to 0.
REQ-025 The period SHALL be computed from tempo sampled only at counter reload (start and each tick); a tempo change mid-beat SHALL NOT alter the current beat.
REQ-026 On beat_tick with rom_last = 0, step_addr SHALL increment, wrapping 63 to 0.
REQ-027 On beat_tick with rom_last = 1:
- step_addr SHALL become 0;
- the FSM SHALL stay in PLAY if loop_en = 1, else go to IDLE.
REQ-028 song_sel changes SHALL be ignored except at the IDLE-to-PLAY transition.
REQ-029 note_out SHALL be registered, one cycle after its inputs:
- key_note if key_note != 0 (manual priority);
- else rom_note if in PLAY or PAUSE;
- else 0.
REQ-030 Manual notes SHALL NOT pause or advance the song; the song continues underneath.
REQ-031 playing SHALL be registered and reflect the current state.

Reset
REQ-032 While RESET = 1, the block SHALL immediately force:
- state = IDLE;
- song_id = 0;
- step_addr = 0;
- counter = 0;
- note_out = 0;
- beat_tick = 0;
- playing = 0;
- manual_active = 0.
REQ-033 After RESET is released, the block SHALL wait in IDLE for play_btn; a reset during PLAY SHALL abandon the song with no further ticks.

Verification (BASE_DIV = 8)
REQ-034 Start: song_sel = 2, tempo = 0, play_btn -> playing = 1, song_id = 2, first beat_tick 8 cycles after start, step_addr 0->1.
REQ-035 Tempo: tempo = 2 latched at start -> ticks every 2 cycles; tempo changed to 0 mid-beat -> the current beat still lasts 2 cycles, then beats last 8 cycles.
REQ-036 End: rom_last = 1 at step 30, loop_en = 0 -> at the tick, step_addr = 0 and IDLE; with loop_en = 1 -> step_addr = 0 and still PLAY.
REQ-037 Pause: pause at counter 5 for 20 cycles, then resume -> the next tick arrives 3 cycles after resume with step_addr unchanged during the pause.
REQ-038 Arbitration: key_note = 5 while rom_note = 3 in PLAY -> note_out = 5 and manual_active = 1 one cycle later; key_note = 0 -> note_out = 3; in IDLE with key_note = 0 -> note_out = 0.
REQ-039 Collisions: play_btn and stop_btn together in PLAY -> IDLE; RESET asserted mid-beat -> all outputs 0 within the same cycle, with no beat_tick after release until play_btn.
